// File: rtl/bus_bridge_mc.sv
// Multi-channel CPU-to-slave bus bridge: base/mask address decode, registered req/ready handshake, one response per request.
// Optional macro BRIDGE_TIMEOUT_EN adds an ACCESS wait counter that aborts stalled slaves with an error response.
module bus_bridge_mc #(
    parameter int unsigned                ADDR_W      = 16,
    parameter int unsigned                DATA_W      = 32,
    parameter int unsigned                NUM_SLV     = 5,
    parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_BASE    = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_MASK    = '0,
    parameter int unsigned                TIMEOUT_CYC = 15
) (
    input  logic                      clk_from_cpu,
    input  logic                      rst_from_cpu,
    input  logic                      req_from_cpu,
    input  logic [ADDR_W-1:0]         addr_from_cpu,
    input  logic                      wen_from_cpu,
    input  logic [DATA_W-1:0]         wdata_from_cpu,
    input  logic [DATA_W/8-1:0]       be_from_cpu,
    output logic                      ready_to_cpu,
    output logic [DATA_W-1:0]         rdata_to_cpu,
    output logic                      err_to_cpu,
    output logic [NUM_SLV-1:0]        sel_to_slv,
    output logic [ADDR_W-1:0]         addr_to_slv,
    output logic                      wen_to_slv,
    output logic [DATA_W-1:0]         wdata_to_slv,
    output logic [DATA_W/8-1:0]       be_to_slv,
    input  logic [NUM_SLV*DATA_W-1:0] rdata_from_slv,
    input  logic [NUM_SLV-1:0]        ready_from_slv
);

    localparam int unsigned BE_W = DATA_W / 8;

    if (NUM_SLV < 1 || NUM_SLV > 16 || (DATA_W % 8) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("bus_bridge_mc: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t               state, state_d;
    logic [NUM_SLV-1:0]   sel_d;
    logic                 wen_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [DATA_W-1:0]    wdata_d;
    logic [BE_W-1:0]      be_d;
    logic                 ready_d;
    logic                 err_d;
    logic [DATA_W-1:0]    rdata_d;

    logic [NUM_SLV-1:0]   dec_sel_c;
    logic [ADDR_W-1:0]    dec_mask_c;
    logic                 dec_hit_c;
    logic [DATA_W-1:0]    slv_rdata_c;
    logic                 slv_ready_c;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]     wait_cnt, wait_cnt_d;
    logic [CNT_W-1:0]     wait_inc_c;
    assign wait_inc_c = wait_cnt + CNT_W'(1);
`endif

    // Address decode on the live request; scanning downward lets the lowest matching index win.
    always_comb begin
        dec_sel_c  = '0;
        dec_mask_c = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr_from_cpu & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                dec_sel_c    = '0;
                dec_sel_c[i] = 1'b1;
                dec_mask_c   = SLV_MASK[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign dec_hit_c = |dec_sel_c;

    // Return path from the selected slave only; other ready bits are masked off.
    always_comb begin
        slv_rdata_c = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_to_slv[i]) begin
                slv_rdata_c = slv_rdata_c | rdata_from_slv[i*DATA_W +: DATA_W];
            end
        end
    end

    assign slv_ready_c = |(ready_from_slv & sel_to_slv);

    // Next-state and next-output logic; every output register is loaded from here.
    always_comb begin
        state_d = state;
        sel_d   = sel_to_slv;
        wen_d   = wen_to_slv;
        addr_d  = addr_to_slv;
        wdata_d = wdata_to_slv;
        be_d    = be_to_slv;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_to_cpu;
`ifdef BRIDGE_TIMEOUT_EN
        wait_cnt_d = wait_cnt;
`endif
        case (state)
            IDLE: begin
                if (req_from_cpu) begin
                    wdata_d = wdata_from_cpu;
                    be_d    = be_from_cpu;
                    if (dec_hit_c) begin
                        sel_d   = dec_sel_c;
                        wen_d   = wen_from_cpu;
                        addr_d  = addr_from_cpu & ~dec_mask_c;
                        state_d = ACCESS;
`ifdef BRIDGE_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ERR;
                    end
                end
            end
            ACCESS: begin
                if (slv_ready_c) begin
                    sel_d   = '0;
                    wen_d   = 1'b0;
                    ready_d = 1'b1;
                    rdata_d = wen_to_slv ? '0 : slv_rdata_c;
                    state_d = RESP;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else begin
                    wait_cnt_d = wait_inc_c;
                    if (wait_inc_c == CNT_W'(TIMEOUT_CYC)) begin
                        sel_d   = '0;
                        wen_d   = 1'b0;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ERR;
                    end
                end
`endif
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_from_cpu or negedge rst_from_cpu) begin
        if (!rst_from_cpu) begin
            state        <= IDLE;
            sel_to_slv   <= '0;
            wen_to_slv   <= 1'b0;
            addr_to_slv  <= '0;
            wdata_to_slv <= '0;
            be_to_slv    <= '0;
            ready_to_cpu <= 1'b0;
            err_to_cpu   <= 1'b0;
            rdata_to_cpu <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            state        <= state_d;
            sel_to_slv   <= sel_d;
            wen_to_slv   <= wen_d;
            addr_to_slv  <= addr_d;
            wdata_to_slv <= wdata_d;
            be_to_slv    <= be_d;
            ready_to_cpu <= ready_d;
            err_to_cpu   <= err_d;
            rdata_to_cpu <= rdata_d;
`ifdef BRIDGE_TIMEOUT_EN
            wait_cnt     <= wait_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_bridge_mc.sv
// Randomized self-checking bench for bus_bridge_mc against a transaction-level reference model.
// Timeout scenarios are exercised only when BRIDGE_TIMEOUT_EN is defined.
module tb_bus_bridge_mc;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NSLV   = 4;
    localparam int unsigned TOUT   = 4;
`ifdef BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [15:0] BASE [NSLV] = '{16'h0000, 16'hF000, 16'hF040, 16'hF040};
    localparam logic [15:0] MASK [NSLV] = '{16'h8000, 16'hFFF0, 16'hFFC0, 16'hFFC0};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic [15:0]       addr;
    logic              wen;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              ready_to_cpu;
    logic [31:0]       rdata_to_cpu;
    logic              err_to_cpu;
    logic [NSLV-1:0]   sel_to_slv;
    logic [15:0]       addr_to_slv;
    logic              wen_to_slv;
    logic [31:0]       wdata_to_slv;
    logic [3:0]        be_to_slv;
    logic [NSLV*32-1:0] rdata_from_slv;
    logic [NSLV-1:0]   ready_from_slv;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_rd = '0;

    bus_bridge_mc #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_SLV    (NSLV),
        .SLV_BASE   ({BASE[3], BASE[2], BASE[1], BASE[0]}),
        .SLV_MASK   ({MASK[3], MASK[2], MASK[1], MASK[0]}),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk_from_cpu  (clk),
        .rst_from_cpu  (rst_n),
        .req_from_cpu  (req),
        .addr_from_cpu (addr),
        .wen_from_cpu  (wen),
        .wdata_from_cpu(wdata),
        .be_from_cpu   (be),
        .ready_to_cpu  (ready_to_cpu),
        .rdata_to_cpu  (rdata_to_cpu),
        .err_to_cpu    (err_to_cpu),
        .sel_to_slv    (sel_to_slv),
        .addr_to_slv   (addr_to_slv),
        .wen_to_slv    (wen_to_slv),
        .wdata_to_slv  (wdata_to_slv),
        .be_to_slv     (be_to_slv),
        .rdata_from_slv(rdata_from_slv),
        .ready_from_slv(ready_from_slv)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Lowest-index window match, -1 when no window claims the address.
    function automatic int decode(input logic [15:0] a);
        for (int i = 0; i < NSLV; i++)
            if ((a & MASK[i]) == BASE[i]) return i;
        return -1;
    endfunction

    task automatic drive_garbage();
        req   = 1'($urandom);
        addr  = 16'($urandom);
        wen   = 1'($urandom);
        wdata = $urandom;
        be    = 4'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   64'(sel_to_slv),   64'd0);
        check({tag, "_wen"},   64'(wen_to_slv),   64'd0);
        check({tag, "_rdy"},   64'(ready_to_cpu), 64'd0);
        check({tag, "_err"},   64'(err_to_cpu),   64'd0);
        check({tag, "_rdata"}, 64'(rdata_to_cpu), 64'd0);
        check({tag, "_addr"},  64'(addr_to_slv),  64'd0);
        check({tag, "_wdata"}, 64'(wdata_to_slv), 64'd0);
        check({tag, "_be"},    64'(be_to_slv),    64'd0);
    endtask

    // One CPU transaction; entered and left on a negedge at the start of an IDLE cycle.
    // k is the ACCESS cycle in which the selected slave raises ready.
    task automatic txn(input logic [15:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] b, input int k, input logic [31:0] rv);
        int   idx;
        int   last_c;
        int   commits;
        bit   timed_out;
        logic [NSLV-1:0] noise;
        idx     = decode(a);
        commits = 0;
        req = 1'b1; addr = a; wen = w; wdata = wd; be = b;
        ready_from_slv = '0;
        rdata_from_slv = {$urandom, $urandom, $urandom, $urandom};
        if (idx >= 0) rdata_from_slv[idx*32 +: 32] = rv;
        if (idx < 0) begin
            @(negedge clk);
            drive_garbage();
            check("miss_rdy",   64'(ready_to_cpu), 64'd1);
            check("miss_err",   64'(err_to_cpu),   64'd1);
            check("miss_rdata", 64'(rdata_to_cpu), 64'd0);
            check("miss_sel",   64'(sel_to_slv),   64'd0);
            check("miss_wen",   64'(wen_to_slv),   64'd0);
            last_rd = '0;
        end else begin
            timed_out = TO_EN && (k > int'(TOUT));
            last_c    = timed_out ? int'(TOUT) : k;
            for (int c = 1; c <= last_c; c++) begin
                @(negedge clk);
                drive_garbage();
                check("acc_sel",   64'(sel_to_slv),   64'(1) << idx);
                check("acc_wen",   64'(wen_to_slv),   64'(w));
                check("acc_addr",  64'(addr_to_slv),  64'(a & ~MASK[idx]));
                check("acc_wdata", 64'(wdata_to_slv), 64'(wd));
                check("acc_be",    64'(be_to_slv),    64'(b));
                check("acc_rdy",   64'(ready_to_cpu), 64'd0);
                noise = NSLV'($urandom);
                noise[idx] = (c == k);
                ready_from_slv = noise;
                if (sel_to_slv[idx] && wen_to_slv && ready_from_slv[idx]) commits++;
            end
            @(negedge clk);
            drive_garbage();
            ready_from_slv = NSLV'($urandom);
            check("rsp_rdy",   64'(ready_to_cpu), 64'd1);
            check("rsp_err",   64'(err_to_cpu),   64'(timed_out));
            check("rsp_rdata", 64'(rdata_to_cpu), (timed_out || w) ? 64'd0 : 64'(rv));
            check("rsp_sel",   64'(sel_to_slv),   64'd0);
            check("rsp_wen",   64'(wen_to_slv),   64'd0);
            if (w && !timed_out) check("commits", 64'(commits), 64'd1);
            last_rd = (timed_out || w) ? 32'd0 : rv;
        end
        @(negedge clk);
        req = 1'b0;
        ready_from_slv = '0;
        check("idle_rdy",   64'(ready_to_cpu), 64'd0);
        check("idle_err",   64'(err_to_cpu),   64'd0);
        check("idle_rdata", 64'(rdata_to_cpu), 64'(last_rd));
        check("idle_sel",   64'(sel_to_slv),   64'd0);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] r;
        case ($urandom_range(0, 3))
            0:       r = {1'b0, 15'($urandom)};
            1:       r = 16'hF000 | 16'(4'($urandom));
            2:       r = 16'hF040 | 16'(6'($urandom));
            default: r = 16'($urandom);
        endcase
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        req = 1'b0; addr = '0; wen = 1'b0; wdata = '0; be = '0;
        ready_from_slv = '0;
        rdata_from_slv = '0;
        #12;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        txn(16'h4008, 1'b0, 32'h0,        4'hF,    1, 32'hDEADBEEF);
        txn(16'hF004, 1'b1, 32'h12345678, 4'b0011, 4, $urandom);
        txn(16'hF100, 1'b0, 32'h0,        4'hF,    1, 32'h0);
        txn(16'hF040, 1'b0, 32'h0,        4'hF,    2, 32'hCAFEF00D);
        txn(16'hF07C, 1'b1, 32'hA5A5A5A5, 4'b1000, 1, 32'h0);

        if (TO_EN) begin
            txn(16'hF008, 1'b0, 32'h0, 4'hF, 1000, 32'h11111111);
            txn(16'h0010, 1'b0, 32'h0, 4'hF, 1,    32'h22222222);
            txn(16'hF048, 1'b1, 32'h5, 4'h1, int'(TOUT), 32'h0);
        end

        // Asynchronous reset in the middle of an ACCESS wait.
        req = 1'b1; addr = 16'hF008; wen = 1'b1; wdata = 32'h77777777; be = 4'hF;
        @(negedge clk);
        req = 1'b0;
        check("pre_rst_sel", 64'(sel_to_slv), 64'b0010);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ready_from_slv = '1;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        check("rst_hold_rdy", 64'(ready_to_cpu), 64'd0);
        ready_from_slv = '0;
        rst_n = 1'b1;
        last_rd = '0;
        txn(16'h0100, 1'b0, 32'h0, 4'hF, 1, 32'h600DBEEF);

        for (int n = 0; n < 80; n++) begin
            txn(rand_addr(), 1'($urandom), $urandom, 4'($urandom),
                TO_EN ? int'($urandom_range(1, 7)) : int'($urandom_range(1, 6)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_bridge_mc.md
# bus_bridge_mc

Parametrised multi-channel bus bridge between the CPU data port and NUM_SLV memory-mapped slaves (DRAM, 7-seg, LEDs, switches, keys, ...). It decodes each request against per-slave base/mask windows and runs a registered request/ready handshake toward the selected slave. Every transaction, including unmapped accesses, returns exactly one response to the CPU with read data or an error flag.

## Interface
- ADDR_W, 16, address width
- DATA_W, 32, data width; multiple of 8
- NUM_SLV, 5, slave channel count, 1..16
- SLV_BASE, 0, packed NUM_SLV*ADDR_W; base address of slave i is field i
- SLV_MASK, 0, packed NUM_SLV*ADDR_W; slave i matches when (addr & mask_i) == base_i
- TIMEOUT_CYC, 15, maximum ACCESS cycles before an error; at least 1
- clk_from_cpu  in  1  single clock, rising edge
- rst_from_cpu  in  1  reset, asynchronous, active-low
- req_from_cpu  in  1  request strobe, sampled in IDLE only
- addr_from_cpu  in  ADDR_W  byte address
- wen_from_cpu  in  1  1 = write, 0 = read
- wdata_from_cpu  in  DATA_W  write data
- be_from_cpu  in  DATA_W/8  byte enables
- ready_to_cpu  out  1  one-cycle response pulse
- rdata_to_cpu  out  DATA_W  read data, valid while ready_to_cpu is high
- err_to_cpu  out  1  error qualifier, valid with ready_to_cpu
- sel_to_slv  out  NUM_SLV  one-hot slave select
- addr_to_slv  out  ADDR_W  region offset: latched addr & ~mask_sel
- wen_to_slv  out  1  write enable, high only together with a sel bit
- wdata_to_slv  out  DATA_W  latched write data
- be_to_slv  out  DATA_W/8  latched byte enables
- rdata_from_slv  in  NUM_SLV*DATA_W  per-slave read data
- ready_from_slv  in  NUM_SLV  per-slave completion

## Operation
- States are IDLE, ACCESS, RESP and ERR.
- IDLE:
  - On req_from_cpu, latch addr, wen, wdata and be.
  - Decode the latched address; the lowest matching index wins.
  - Hit: go to ACCESS with sel_to_slv[i]=1. Miss: go to ERR.
  - req_from_cpu is ignored in every state except IDLE.
- ACCESS:
  - sel, wen, addr, wdata and be are held stable.
  - A write commits on the cycle where sel&wen&ready_from_slv[i] are all high.
  - On ready_from_slv[i]: capture rdata_from_slv field i (reads only; writes capture 0), drop sel and wen, go to RESP.
  - ready_from_slv bits of unselected slaves are ignored.
- RESP: ready_to_cpu=1 and err_to_cpu=0 for one cycle, then go to IDLE.
- ERR: ready_to_cpu=1, err_to_cpu=1 and rdata_to_cpu=0 for one cycle, then go to IDLE. No slave is touched.
- Outside the response cycle, rdata_to_cpu holds its last value and err_to_cpu=0.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - sel_to_slv, wen_to_slv, ready_to_cpu, err_to_cpu, rdata_to_cpu, addr_to_slv, wdata_to_slv and be_to_slv all go to 0.
  - An in-flight slave transaction is abandoned without a response.

## Timing
- All outputs are registered.
- Request sampled in cycle 0:
  - Hit: sel is high from cycle 1.
  - Slave with ready tied high: ready_from_slv seen in cycle 1, ready_to_cpu in cycle 2. This is the minimum hit latency, 2 cycles.
  - Slave asserting ready in cycle k (k ≥ 1): ready_to_cpu in cycle k+1.
  - Miss: ready_to_cpu and err_to_cpu in cycle 1.
- Maximum throughput is one hit per 3 cycles (IDLE, ACCESS, RESP).
- A request held high through RESP starts a new transaction only after the return to IDLE.

## Configuration
- BRIDGE_TIMEOUT_EN defined:
  - A wait counter of width $clog2(TIMEOUT_CYC+1) clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When the counter reaches TIMEOUT_CYC: drop sel and wen, go to ERR.
  - ready arriving in the same cycle as the limit takes priority and gives a normal RESP.
- BRIDGE_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

## Test plan
Configuration: NUM_SLV=3; slave0 base 0x0000 mask 0x8000; slave1 base 0xF000 mask 0xFFF0; slave2 base 0xF040 mask 0xFFC0.
- Read 0x4008, slave0 ready tied high, rdata0=0xDEADBEEF -> sel=3'b001, addr_to_slv=0x4008, ready_to_cpu in cycle 2, rdata_to_cpu=0xDEADBEEF, err=0.
- Write 0xF004, wdata=0x12345678, be=4'b0011, slave1 ready after 3 wait cycles -> sel=3'b010, addr_to_slv=0x0004, wen held through the wait, one commit, ready_to_cpu in cycle 5.
- Read 0xF100 (unmapped) -> ready_to_cpu and err_to_cpu in cycle 1, rdata_to_cpu=0, sel_to_slv stays 0.
- Overlap: add slave3 base 0xF040 mask 0xFFC0 (identical to slave2) -> access to 0xF040 selects slave2 only.
- BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=4, slave never ready -> sel drops after 4 ACCESS cycles, err response, next request to slave0 completes normally.
- Deassert rst_from_cpu during ACCESS -> all outputs 0 immediately, no ready_to_cpu; after release a new read completes with 2-cycle latency.
